// File: rtl/enc_pkg.sv
// Shared types and constants for the sequential 32-to-5 encoder.
package enc_pkg;

    localparam int unsigned ENC_WIDTH = 32;
    localparam int unsigned ENC_IDX_W = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } enc_state_t;

endpackage

// File: rtl/pri_enc_32to5.sv
// Combinational lowest-set-bit finder: vector -> {found, idx}.
module pri_enc_32to5
    import enc_pkg::*;
#(
    parameter int unsigned WIDTH = ENC_WIDTH,
    parameter int unsigned IDX_W = ENC_IDX_W
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set bit is the one that sticks.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/enc_32to5_seq.sv
// Sequential 32-to-5 encoder: drains a request mask one index per handshake.
// Define RR_PRIORITY_EN for round-robin selection; otherwise lowest bit wins.
module enc_32to5_seq
    import enc_pkg::*;
#(
    parameter int unsigned WIDTH = ENC_WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    enc_state_t       state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             one_left;

`ifdef RR_PRIORITY_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] masked_vec;
    logic             m_found, u_found;
    logic [IDX_W-1:0] m_idx, u_idx;

    assign masked_vec = pend_q & ({WIDTH{1'b1}} << ptr_q);

    pri_enc_32to5 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pri_masked (
        .vec   (masked_vec),
        .found (m_found),
        .idx   (m_idx)
    );

    pri_enc_32to5 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pri_full (
        .vec   (pend_q),
        .found (u_found),
        .idx   (u_idx)
    );

    // Nothing at/above ptr means wrap around to the lowest pending bit.
    assign sel_found = m_found | u_found;
    assign sel_idx   = m_found ? m_idx : u_idx;
`else
    pri_enc_32to5 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pri (
        .vec   (pend_q),
        .found (sel_found),
        .idx   (sel_idx)
    );
`endif

    assign one_left  = (pend_q != '0) && ((pend_q & (pend_q - WIDTH'(1))) == '0);

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == DRAIN);
    assign out_valid = (state_q == DRAIN) && sel_found;
    assign out_idx   = out_valid ? sel_idx : '0;
    assign out_last  = out_valid && one_left;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
`ifdef RR_PRIORITY_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_vec != '0) begin
                    pend_d  = in_vec;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    pend_d = pend_q & ~({{(WIDTH-1){1'b0}}, 1'b1} << sel_idx);
`ifdef RR_PRIORITY_EN
                    ptr_d  = sel_idx + IDX_W'(1);
`endif
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
`ifdef RR_PRIORITY_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
`ifdef RR_PRIORITY_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_enc_32to5_seq.sv
// Directed bench for enc_32to5_seq; honours RR_PRIORITY_EN for the ordering test.
module tb_enc_32to5_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    enc_32to5_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present v for one cycle; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] v);
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_vec = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_vec = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_idx, out_last, busy, in_ready} !== {1'b0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b idx=%0d last=%b busy=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, out_idx, out_last, busy, in_ready);
        end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        send(32'h0000_0001);
        tests++;
        if ({out_valid, out_idx, out_last, in_ready} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL single_beat: got v=%b idx=%0d last=%b rdy=%b, want 1 0 1 0",
                     out_valid, out_idx, out_last, in_ready);
        end
        @(posedge clk); #1;
        tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL single_done: got v=%b rdy=%b busy=%b, want 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_multi();
        logic [4:0] exp_idx [3] = '{5'd0, 5'd4, 5'd31};
        logic       exp_last[3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        out_ready = 1'b1;
        send(32'h8000_0011);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({out_valid, busy, out_idx, out_last} !== {1'b1, 1'b1, exp_idx[i], exp_last[i]}) begin
                fails++;
                $display("FAIL multi_beat%0d: got v=%b busy=%b idx=%0d last=%b, want 1 1 %0d %b",
                         i, out_valid, busy, out_idx, out_last, exp_idx[i], exp_last[i]);
            end
            @(posedge clk); #1;
        end
        tests++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            fails++;
            $display("FAIL multi_done: got v=%b busy=%b rdy=%b, want 0 0 1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        send(32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({out_valid, out_idx, out_last} !== {1'b1, 5'd8, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b idx=%0d last=%b, want 1 8 0",
                         i, out_valid, out_idx, out_last);
            end
            if (i == 2) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if ({out_valid, out_idx, out_last} !== {1'b1, 5'd9, 1'b1}) begin
            fails++;
            $display("FAIL bp_second: got v=%b idx=%0d last=%b, want 1 9 1",
                     out_valid, out_idx, out_last);
        end
        @(posedge clk); #1;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL bp_done: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero();
        do_reset();
        out_ready = 1'b1;
        send(32'h0);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({out_valid, busy, in_ready} !== 3'b001) begin
                fails++;
                $display("FAIL zero_vec%0d: got v=%b busy=%b rdy=%b, want 0 0 1",
                         i, out_valid, busy, in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        send(32'h0000_000F);
        @(posedge clk); #1;
        tests++;
        if ({out_valid, out_idx} !== {1'b1, 5'd1}) begin
            fails++;
            $display("FAIL mid_second: got v=%b idx=%0d, want 1 1", out_valid, out_idx);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset: got v=%b busy=%b, want 0 0", out_valid, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({out_valid, in_ready, busy} !== 3'b010) begin
                fails++;
                $display("FAIL mid_residual%0d: got v=%b rdy=%b busy=%b, want 0 1 0",
                         i, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_order();
        logic [4:0] first_idx;
        logic [4:0] second_idx;
`ifdef RR_PRIORITY_EN
        first_idx  = 5'd5;
        second_idx = 5'd0;
`else
        first_idx  = 5'd0;
        second_idx = 5'd5;
`endif
        do_reset();
        out_ready = 1'b1;
        send(32'h0000_0010);
        tests++;
        if ({out_valid, out_idx, out_last} !== {1'b1, 5'd4, 1'b1}) begin
            fails++;
            $display("FAIL order_a: got v=%b idx=%0d last=%b, want 1 4 1",
                     out_valid, out_idx, out_last);
        end
        @(posedge clk); #1;
        send(32'h0000_0021);
        tests++;
        if ({out_valid, out_idx, out_last} !== {1'b1, first_idx, 1'b0}) begin
            fails++;
            $display("FAIL order_b0: got v=%b idx=%0d last=%b, want 1 %0d 0",
                     out_valid, out_idx, out_last, first_idx);
        end
        @(posedge clk); #1;
        tests++;
        if ({out_valid, out_idx, out_last} !== {1'b1, second_idx, 1'b1}) begin
            fails++;
            $display("FAIL order_b1: got v=%b idx=%0d last=%b, want 1 %0d 1",
                     out_valid, out_idx, out_last, second_idx);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_order();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
